mix_columns_seq: RTL and testbench

Sequential, parametrised (Inv)MixColumns engine for Rijndael states of NUM_COLS 32-bit columns.
- Accepts a whole state over a valid/ready handshake.
- Transforms COLS_PER_CYCLE columns per clock, in place, in an internal state register.
- Returns the result over a second valid/ready handshake.
- Sits between the (Inv)ShiftRows and AddRoundKey stages of the round datapath.
- Replaces the fixed single-column, inverse-only combinational row multipliers.

---
 rtl/mix_columns_seq_pkg.sv | 40 ++++
 rtl/mix_columns_seq_if.sv | 26 ++
 rtl/mix_columns_seq_word.sv | 39 +++
 rtl/mix_columns_seq.sv | 116 +++++++++++
 tb/tb_mix_columns_seq.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mix_columns_seq_pkg.sv
// Shared GF(2^8) helpers, coefficient constants and types for the
// sequential (Inv)MixColumns engine.
package mix_columns_pkg;

  // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] GF_POLY = 8'h1B;

  // Row-0 coefficients, packed with k0 in the low byte. Row r uses the
  // same set rotated right by r positions.
  localparam logic [31:0] FWD_COEF = {8'h01, 8'h01, 8'h03, 8'h02};
  localparam logic [31:0] INV_COEF = {8'h09, 8'h0d, 8'h0b, 8'h0e};

  typedef logic [31:0] col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Multiply by x in GF(2^8): shift left and fold the carried-out bit back in.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Multiply by a constant using an xtime chain; with a constant c the
  // unused links of the chain fold away.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] b, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h00;
    pw  = b;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc = acc ^ pw;
      pw = xtime(pw);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the mix_columns_seq engine: input state channel,
// output state channel and a busy indicator.
interface mix_columns_seq_if #(
  parameter int NUM_COLS = 4
);

  logic                    in_valid;
  logic                    in_ready;
  logic                    mode;
  logic [32*NUM_COLS-1:0]  data_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [32*NUM_COLS-1:0]  data_out;
  logic                    busy;

  modport master (
    output in_valid, mode, data_in, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  in_valid, mode, data_in, out_ready,
    output in_ready, out_valid, data_out, busy
  );

endinterface

// File: rtl/mix_columns_seq_word.sv
// mix_column_word: combinational transform of one 32-bit column.
// mode = 1 selects InvMixColumns, mode = 0 selects MixColumns.
// Optional feature macro MIXCOL_FWD_EN: when undefined only the inverse
// datapath is built and mode is ignored.
module mix_column_word
  import mix_columns_pkg::*;
(
  input  logic mode,
  input  col_t col_in,
  output col_t col_out
);

  // Matrix multiply of a column; k holds row-0 coefficients (k0 in low byte),
  // row r reads them rotated right by r.
  function automatic col_t col_mul(input col_t c, input logic [31:0] k);
    col_t o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        o[8*r +: 8] = o[8*r +: 8] ^ gf_mul_const(c[8*j +: 8], k[8*((j - r + 4) % 4) +: 8]);
      end
    end
    return o;
  endfunction

  col_t inv_col;
  assign inv_col = col_mul(col_in, INV_COEF);

`ifdef MIXCOL_FWD_EN
  col_t fwd_col;
  assign fwd_col = col_mul(col_in, FWD_COEF);
  assign col_out = mode ? inv_col : fwd_col;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign col_out     = inv_col;
`endif

endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential (Inv)MixColumns over a NUM_COLS-column
// Rijndael state, COLS_PER_CYCLE columns per clock, transformed in place.
// Optional feature macro MIXCOL_FWD_EN (see mix_column_word): enables the
// forward transform; otherwise every state gets InvMixColumns.
module mix_columns_seq
  import mix_columns_pkg::*;
#(
  parameter int NUM_COLS       = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input logic              clk,
  input logic              rst,
  mix_columns_seq_if.slave bus
);

  localparam int W     = 32 * NUM_COLS;
  localparam int CNT_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  if ((NUM_COLS % COLS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("mix_columns_seq: COLS_PER_CYCLE must divide NUM_COLS");
  end

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic [W-1:0]     st;
  logic [W-1:0]     st_next;
  logic             load;
  logic             step;
  logic             last;
  logic             in_ready;
  logic             out_valid;
  logic             busy;

  col_t grp_in  [COLS_PER_CYCLE];
  col_t grp_out [COLS_PER_CYCLE];

  assign last = (cnt == CNT_W'(NUM_COLS - COLS_PER_CYCLE));

  // One column transformer per lane, fed from the group the counter points at.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_word
    assign grp_in[g] = st[32*(int'(cnt) + g) +: 32];
    mix_column_word u_word (
      .mode    (mode_q),
      .col_in  (grp_in[g]),
      .col_out (grp_out[g])
    );
  end

  // Splice the transformed group back into the state image.
  always_comb begin
    st_next = st;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      st_next[32*(int'(cnt) + g) +: 32] = grp_out[g];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state and handshake decode.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State image, column counter and latched mode; the counter returns to
  // zero after the last group so it never points past the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= '0;
      cnt    <= '0;
      mode_q <= 1'b1;
    end else if (load) begin
      st     <= bus.data_in;
      cnt    <= '0;
      mode_q <= bus.mode;
    end else if (step) begin
      st  <= st_next;
      cnt <= last ? '0 : cnt + CNT_W'(COLS_PER_CYCLE);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.data_out  = st;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: a 4x1 instance and an 8x2 instance, directed
// steps with a scoreboard of expected states per instance.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [127:0] q4 [$];
  logic [255:0] q8 [$];

`ifdef MIXCOL_FWD_EN
  localparam bit FWD_BUILT = 1'b1;
`else
  localparam bit FWD_BUILT = 1'b0;
`endif

  always #5 clk = ~clk;

  mix_columns_seq_if #(.NUM_COLS(4)) b4 ();
  mix_columns_seq_if #(.NUM_COLS(8)) b8 ();

  mix_columns_seq #(.NUM_COLS(4), .COLS_PER_CYCLE(1)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (b4.slave)
  );

  mix_columns_seq #(.NUM_COLS(8), .COLS_PER_CYCLE(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  // Carry-less product followed by long division by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] c, input bit inv);
    logic [7:0] s0, s1, s2, s3, ka, kb, kc, kd, o0, o1, o2, o3;
    s0 = c[7:0]; s1 = c[15:8]; s2 = c[23:16]; s3 = c[31:24];
    if (inv) begin ka = 8'h0e; kb = 8'h0b; kc = 8'h0d; kd = 8'h09; end
    else     begin ka = 8'h02; kb = 8'h03; kc = 8'h01; kd = 8'h01; end
    o0 = gmul(s0, ka) ^ gmul(s1, kb) ^ gmul(s2, kc) ^ gmul(s3, kd);
    o1 = gmul(s0, kd) ^ gmul(s1, ka) ^ gmul(s2, kb) ^ gmul(s3, kc);
    o2 = gmul(s0, kc) ^ gmul(s1, kd) ^ gmul(s2, ka) ^ gmul(s3, kb);
    o3 = gmul(s0, kb) ^ gmul(s1, kc) ^ gmul(s2, kd) ^ gmul(s3, ka);
    return {o3, o2, o1, o0};
  endfunction

  function automatic logic [127:0] model4(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[32*c +: 32] = model_col(d[32*c +: 32], m | !FWD_BUILT);
    return r;
  endfunction

  function automatic logic [255:0] model8(input logic [255:0] d, input logic m);
    logic [255:0] r;
    for (int c = 0; c < 8; c++) r[32*c +: 32] = model_col(d[32*c +: 32], m | !FWD_BUILT);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send4(input logic [127:0] d, input logic m, input logic [127:0] exp);
    int n;
    n = 0;
    b4.data_in  = d;
    b4.mode     = m;
    b4.in_valid = 1'b1;
    while (!b4.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept4", b4.in_ready, 1);
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    q4.push_back(exp);
    chk("busy4", b4.busy, 1);
  endtask

  task automatic recv4(input int exp_lat);
    int n;
    n = 0;
    b4.out_ready = 1'b0;
    while (!b4.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (exp_lat >= 0) chk("latency4", n, exp_lat);
    if (q4.size() == 0) chk("scoreboard4_empty", 0, 1);
    else                chk("data4", b4.data_out, q4.pop_front());
    b4.out_ready = 1'b1;
    @(posedge clk); #1;
    b4.out_ready = 1'b0;
    chk("idle4_in_ready", b4.in_ready, 1);
  endtask

  task automatic send8(input logic [255:0] d, input logic m, input logic [255:0] exp);
    int n;
    n = 0;
    b8.data_in  = d;
    b8.mode     = m;
    b8.in_valid = 1'b1;
    while (!b8.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("accept8", b8.in_ready, 1);
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    q8.push_back(exp);
    chk("busy8", b8.busy, 1);
  endtask

  task automatic recv8(input int exp_lat);
    int n;
    n = 0;
    b8.out_ready = 1'b0;
    while (!b8.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("latency8", n, exp_lat);
    if (q8.size() == 0) chk("scoreboard8_empty", 0, 1);
    else                chk("data8", b8.data_out, q8.pop_front());
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    chk("idle8_in_ready", b8.in_ready, 1);
  endtask

  initial begin
    logic [127:0] d4, e4, snap;
    logic [255:0] r8, f8;

    rst = 1'b1;
    b4.in_valid = 1'b0; b4.out_ready = 1'b0; b4.mode = 1'b0; b4.data_in = '0;
    b8.in_valid = 1'b0; b8.out_ready = 1'b0; b8.mode = 1'b0; b8.data_in = '0;
    @(posedge clk); #1;
    chk("rst_in_ready",  b4.in_ready, 1);
    chk("rst_out_valid", b4.out_valid, 0);
    chk("rst_busy",      b4.busy, 0);
    chk("rst_data_out",  b4.data_out, 0);
    chk("rst8_in_ready", b8.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Forward vector (inverse applied when the forward path is not built).
    d4 = {4{32'h455313db}};
    send4(d4, 1'b0, FWD_BUILT ? {4{32'hbca14d8e}} : model4(d4, 1'b0));
    recv4(4);

    // Inverse vector, with in_valid toggling garbage while busy.
    d4 = {32'hd6d7d5d5, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
    send4(d4, 1'b1, {32'hd5d4d4d4, 32'h01010101, 32'h5c220af2, 32'h455313db});
    b4.in_valid = 1'b1; b4.data_in = ~d4; b4.mode = 1'b0;
    @(posedge clk); #1;
    b4.in_valid = 1'b0;
    recv4(-1);

    // mode=0 on a column that inverts to 455313db.
    d4 = {4{32'hbca14d8e}};
    send4(d4, 1'b0, FWD_BUILT ? model4(d4, 1'b0) : {4{32'h455313db}});
    recv4(4);

    // Backpressure: ten held cycles in DONE.
    d4 = {$urandom, $urandom, $urandom, $urandom};
    send4(d4, 1'b1, model4(d4, 1'b1));
    begin
      int n;
      n = 0;
      while (!b4.out_valid && n < 50) begin @(posedge clk); #1; n++; end
    end
    snap = b4.data_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_data_stable", b4.data_out, snap);
      chk("bp_out_valid",   b4.out_valid, 1);
      chk("bp_in_ready",    b4.in_ready, 0);
    end
    chk("bp_data", b4.data_out, q4.pop_front());
    b4.out_ready = 1'b1;
    @(posedge clk); #1;
    b4.out_ready = 1'b0;
    chk("bp_release_in_ready",  b4.in_ready, 1);
    chk("bp_release_out_valid", b4.out_valid, 0);

    // Reset in the second BUSY cycle aborts the state.
    d4 = {$urandom, $urandom, $urandom, $urandom};
    send4(d4, 1'b1, model4(d4, 1'b1));
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", b4.out_valid, 0);
    chk("mid_rst_busy",      b4.busy, 0);
    chk("mid_rst_in_ready",  b4.in_ready, 1);
    chk("mid_rst_data_out",  b4.data_out, 0);
    q4.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    d4 = {$urandom, $urandom, $urandom, $urandom};
    send4(d4, 1'b1, model4(d4, 1'b1));
    recv4(4);

    // A few random states of either mode.
    for (int t = 0; t < 3; t++) begin
      d4 = {$urandom, $urandom, $urandom, $urandom};
      e4 = model4(d4, t[0]);
      send4(d4, t[0], e4);
      recv4(4);
    end

    // 8-column, 2 columns per cycle: forward then inverse round trip.
    for (int c = 0; c < 8; c++) r8[32*c +: 32] = $urandom;
    f8 = model8(r8, 1'b0);
    send8(r8, 1'b0, f8);
    recv8(4);
    send8(f8, 1'b1, FWD_BUILT ? r8 : model8(f8, 1'b1));
    recv8(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
